// File: rtl/divu_int_arbiter.sv
// Round-robin front end that shares one unsigned divider between CH requesters.
// Latches the winner's operands, pulses start/gnt, and routes the result back.
module divu_int_arbiter #(
    parameter int unsigned CH    = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         req,
    input  logic [CH*WIDTH-1:0]   a_in,
    input  logic [CH*WIDTH-1:0]   b_in,
    output logic [CH-1:0]         gnt,
    output logic [CH-1:0]         res_valid,
    output logic [$clog2(CH)-1:0] res_ch,
    output logic [WIDTH-1:0]      res_val,
    output logic [WIDTH-1:0]      res_rem,
    output logic                  res_dbz,
    output logic                  busy,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_a,
    output logic [WIDTH-1:0]      div_b,
    input  logic                  div_done,
    input  logic                  div_dbz,
    input  logic [WIDTH-1:0]      div_val,
    input  logic [WIDTH-1:0]      div_rem
);

    localparam int unsigned CW = $clog2(CH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   owner_q, owner_d;

    logic [CH-1:0]    gnt_d, res_valid_d;
    logic [CW-1:0]    res_ch_d;
    logic [WIDTH-1:0] res_val_d, res_rem_d;
    logic             res_dbz_d, busy_d, div_start_d;
    logic [WIDTH-1:0] div_a_d, div_b_d;

    logic            pick_valid;
    logic [CW-1:0]   pick;
    logic [31:0]     idx;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick       = rr_q;
        idx        = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            idx = (32'(rr_q) + i) % CH;
            if (!pick_valid && req[idx[CW-1:0]]) begin
                pick_valid = 1'b1;
                pick       = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        res_valid_d = '0;
        div_start_d = 1'b0;
        res_ch_d    = res_ch;
        res_val_d   = res_val;
        res_rem_d   = res_rem;
        res_dbz_d   = res_dbz;
        div_a_d     = div_a;
        div_b_d     = div_b;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d     = pick;
                    div_a_d     = a_in[32'(pick)*WIDTH +: WIDTH];
                    div_b_d     = b_in[32'(pick)*WIDTH +: WIDTH];
                    gnt_d[pick] = 1'b1;
                    div_start_d = 1'b1;
                    state_d     = StStart;
                end
            end
            // The divider cannot answer in the cycle it is started.
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (div_done) begin
                    res_val_d            = div_val;
                    res_rem_d            = div_rem;
                    res_dbz_d            = div_dbz;
                    res_ch_d             = owner_q;
                    res_valid_d[owner_q] = 1'b1;
                    if (32'(owner_q) == CH - 1) begin
                        rr_d = '0;
                    end else begin
                        rr_d = owner_q + CW'(1);
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            owner_q   <= '0;
            gnt       <= '0;
            res_valid <= '0;
            res_ch    <= '0;
            res_val   <= '0;
            res_rem   <= '0;
            res_dbz   <= 1'b0;
            busy      <= 1'b0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            gnt       <= gnt_d;
            res_valid <= res_valid_d;
            res_ch    <= res_ch_d;
            res_val   <= res_val_d;
            res_rem   <= res_rem_d;
            res_dbz   <= res_dbz_d;
            busy      <= busy_d;
            div_start <= div_start_d;
            div_a     <= div_a_d;
            div_b     <= div_b_d;
        end
    end

endmodule

// File: tb/tb_divu_int_arbiter.sv
// Bench for divu_int_arbiter: behavioural divider stand-in plus a transaction-level
// model that predicts grants, result timing and result values from the operands.
module tb_divu_int_arbiter;

    localparam int unsigned CH    = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CH-1:0]         req;
    logic [CH*WIDTH-1:0]   a_in, b_in;
    logic [CH-1:0]         gnt, res_valid;
    logic [CW-1:0]         res_ch;
    logic [WIDTH-1:0]      res_val, res_rem;
    logic                  res_dbz, busy, div_start;
    logic [WIDTH-1:0]      div_a, div_b;
    logic                  div_done, div_dbz;
    logic [WIDTH-1:0]      div_val, div_rem;

    divu_int_arbiter #(.CH(CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_val   (res_val),
        .res_rem   (res_rem),
        .res_dbz   (res_dbz),
        .busy      (busy),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_dbz   (div_dbz),
        .div_val   (div_val),
        .div_rem   (div_rem)
    );

    always #5 clk = ~clk;

    // Divider stand-in: dbz answers one cycle after start, otherwise WIDTH cycles.
    int unsigned dv_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            div_done <= 1'b0;
            div_dbz  <= 1'b0;
            div_val  <= '0;
            div_rem  <= '0;
            dv_cnt   <= 0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                if (div_b == 0) begin
                    div_done <= 1'b1;
                    div_dbz  <= 1'b1;
                    div_val  <= '1;
                    div_rem  <= div_a;
                    dv_cnt   <= 0;
                end else begin
                    div_dbz <= 1'b0;
                    div_val <= div_a / div_b;
                    div_rem <= div_a % div_b;
                    dv_cnt  <= WIDTH - 1;
                end
            end else if (dv_cnt != 0) begin
                dv_cnt   <= dv_cnt - 1;
                div_done <= (dv_cnt == 1);
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Model state
    int               cyc       = 0;
    bit               m_idle    = 1'b1;
    bit               m_pending = 1'b0;
    int               m_rr      = 0;
    int               m_owner   = 0;
    int               m_due     = 0;
    int               m_grants  = 0;
    logic [WIDTH-1:0] m_a, m_b;
    logic [WIDTH-1:0] e_val = '0, e_rem = '0;
    logic             e_dbz = 1'b0;
    logic [CW-1:0]    e_ch  = '0;

    int            results = 0;
    int            order[$];
    logic [CH-1:0] rearm    = '0;
    logic [CH-1:0] relaunch = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int n, input int a, input int b);
        a_in[n*WIDTH +: WIDTH] = WIDTH'(a);
        b_in[n*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    // One clock edge: predict, compare, then react as the requesters would.
    task automatic tick();
        logic [CH-1:0]       r, e_gnt, e_rv;
        logic [CH*WIDTH-1:0] sa, sb;
        logic                rs, e_start, was_idle, found;
        r = req; sa = a_in; sb = b_in; rs = rst;
        @(posedge clk);
        #1;
        cyc++;
        e_gnt = '0; e_rv = '0; e_start = 1'b0;
        was_idle = m_idle;
        if (rs) begin
            m_idle = 1'b1; m_pending = 1'b0; m_rr = 0;
            e_val = '0; e_rem = '0; e_dbz = 1'b0; e_ch = '0;
        end else begin
            if (m_pending && cyc == m_due) begin
                e_rv[m_owner] = 1'b1;
                e_ch  = CW'(m_owner);
                e_dbz = (m_b == 0);
                e_val = (m_b == 0) ? '1 : m_a / m_b;
                e_rem = (m_b == 0) ? m_a : m_a % m_b;
                m_rr  = (m_owner + 1) % CH;
                m_pending = 1'b0;
                m_idle    = 1'b1;
            end
            if (was_idle && r != 0) begin
                found = 1'b0;
                for (int k = 0; k < CH; k++) begin
                    int n;
                    n = (m_rr + k) % CH;
                    if (!found && r[n]) begin
                        found   = 1'b1;
                        m_owner = n;
                    end
                end
                e_gnt[m_owner] = 1'b1;
                e_start   = 1'b1;
                m_a       = sa[m_owner*WIDTH +: WIDTH];
                m_b       = sb[m_owner*WIDTH +: WIDTH];
                m_due     = cyc + ((m_b == 0) ? 2 : WIDTH + 1);
                m_pending = 1'b1;
                m_idle    = 1'b0;
                m_grants++;
            end
        end
        chk("gnt", gnt, e_gnt);
        chk("div_start", div_start, e_start);
        chk("res_valid", res_valid, e_rv);
        chk("busy", busy, !m_idle);
        chk("res_val", res_val, e_val);
        chk("res_rem", res_rem, e_rem);
        chk("res_dbz", res_dbz, e_dbz);
        chk("res_ch", res_ch, e_ch);
        if (e_start) begin
            chk("div_a", div_a, m_a);
            chk("div_b", div_b, m_b);
        end
        if (res_valid != 0) results++;
        for (int n = 0; n < CH; n++) begin
            if (gnt[n]) begin
                req[n]      = 1'b0;
                relaunch[n] = rearm[n];
                order.push_back(n);
            end else if (relaunch[n]) begin
                req[n]      = 1'b1;
                relaunch[n] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (busy || !m_idle); i++) tick();
        chk("drain_busy", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp3[6];
        int a, b, pat;
        exp3 = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_div_a", div_a, 0);
        rst = 1'b0;

        // 200 / 7 on channel 2
        set_op(2, 200, 7);
        req[2] = 1'b1;
        tick();
        chk("t1_gnt", gnt, 4'b0100);
        repeat (8) tick();
        tick();
        chk("t1_rv", res_valid, 4'b0100);
        chk("t1_val", res_val, 28);
        chk("t1_rem", res_rem, 4);
        chk("t1_ch", res_ch, 2);

        // Divide by zero on channel 0
        set_op(0, 13, 0);
        req[0] = 1'b1;
        tick();
        tick();
        tick();
        chk("t2_rv", res_valid, 4'b0001);
        chk("t2_dbz", res_dbz, 1);
        chk("t2_busy", busy, 0);

        // All channels requesting continuously after reset
        do_reset();
        for (int n = 0; n < CH; n++) set_op(n, 10 * n + 5, n);
        order.delete();
        rearm = '1;
        req   = '1;
        for (int i = 0; i < 200 && order.size() < 6; i++) tick();
        rearm = '0; relaunch = '0; req = '0;
        drain();
        for (int i = 0; i < 6; i++) begin
            chk("t3_order", (i < order.size()) ? order[i] : 99, exp3[i]);
        end

        // Reset while waiting on the divider
        set_op(1, 100, 3);
        req[1] = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_rv", res_valid, 0);
        repeat (12) tick();
        set_op(2, 9, 3);
        req[2] = 1'b1;
        for (int i = 0; i < 20 && res_valid == 0; i++) tick();
        chk("t4_val", res_val, 3);
        chk("t4_rem", res_rem, 0);

        // Withdrawn request and operands changing after grant
        set_op(0, 50, 0);
        req[0] = 1'b1;
        tick();
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        set_op(3, 77, 5);
        req[3] = 1'b1;
        tick();
        tick();
        chk("t5_gnt", gnt, 4'b1000);
        set_op(3, 1, 1);
        for (int i = 0; i < 20 && res_valid == 0; i++) tick();
        chk("t5_val", res_val, 15);
        chk("t5_rem", res_rem, 2);
        chk("t5_ch", res_ch, 3);

        // Random traffic on all channels
        drain();
        results  = 0;
        m_grants = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < CH; n++) begin
                if (!req[n] && !gnt[n] && $urandom_range(0, 3) == 0) begin
                    pat = $urandom_range(0, 5);
                    if (pat == 0) begin
                        a = $urandom_range(0, 255); b = 0;
                    end else if (pat == 1) begin
                        b = $urandom_range(1, 255); a = $urandom_range(0, b - 1);
                    end else if (pat == 2) begin
                        a = 255; b = 1;
                    end else begin
                        a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                    end
                    set_op(n, a, b);
                    req[n] = 1'b1;
                end else if (req[n] && $urandom_range(0, 49) == 0) begin
                    req[n] = 1'b0;
                end
            end
            tick();
        end
        req = '0;
        drain();
        chk("t6_pairs", results, m_grants);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
